// File: rtl/ntsc_pkg.sv
// Shared NTSC line-timing types and defaults for the chroma sequencer.
// The sample-counter width is derived from the longest default segment.
package ntsc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_BREEZE = 3'd2,
        ST_BURST  = 3'd3,
        ST_BACK   = 3'd4,
        ST_ACTIVE = 3'd5,
        ST_FRONT  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        CSEL_ZERO   = 2'd0,
        CSEL_BURST  = 2'd1,
        CSEL_CHROMA = 2'd2
    } chroma_sel_t;

    localparam int unsigned DEF_SYNC_SAMPLES   = 940;
    localparam int unsigned DEF_BREEZE_SAMPLES = 120;
    localparam int unsigned DEF_BURST_SAMPLES  = 500;
    localparam int unsigned DEF_BACK_SAMPLES   = 320;
    localparam int unsigned DEF_ACTIVE_SAMPLES = 10532;
    localparam int unsigned DEF_FRONT_SAMPLES  = 300;
    localparam int unsigned DEF_LINES          = 525;

    function automatic int unsigned max6(int unsigned a, int unsigned b, int unsigned c,
                                         int unsigned d, int unsigned e, int unsigned f);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        if (f > m) m = f;
        return m;
    endfunction

    localparam int unsigned MAX_SEG = max6(DEF_SYNC_SAMPLES, DEF_BREEZE_SAMPLES, DEF_BURST_SAMPLES,
                                           DEF_BACK_SAMPLES, DEF_ACTIVE_SAMPLES, DEF_FRONT_SAMPLES);
    localparam int unsigned CNT_W  = $clog2(MAX_SEG + 1);
    localparam int unsigned LINE_W = 10;

    function automatic seq_state_t next_state(seq_state_t s);
        case (s)
            ST_SYNC:   return ST_BREEZE;
            ST_BREEZE: return ST_BURST;
            ST_BURST:  return ST_BACK;
            ST_BACK:   return ST_ACTIVE;
            ST_ACTIVE: return ST_FRONT;
            ST_FRONT:  return ST_SYNC;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/chroma_sequencer_if.sv
// Control and status bundle between the sample pipeline and the chroma sequencer.
interface chroma_sequencer_if;
    logic                          enable_in;
    logic                          step_in;
    logic                          lo_step_out;
    logic [1:0]                    chroma_sel_out;
    logic                          sync_out;
    logic                          active_out;
    logic                          line_start_out;
    logic [ntsc_pkg::LINE_W-1:0]   line_count_out;
    logic [2:0]                    state_out;

    modport master (
        output enable_in, step_in,
        input  lo_step_out, chroma_sel_out, sync_out, active_out,
               line_start_out, line_count_out, state_out
    );

    modport slave (
        input  enable_in, step_in,
        output lo_step_out, chroma_sel_out, sync_out, active_out,
               line_start_out, line_count_out, state_out
    );
endinterface

// File: rtl/chroma_sequencer_line_timer.sv
// Per-segment sample counter with terminal-count detect for the line sequencer.
module line_timer
    import ntsc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] seg_len,
    output logic             terminal
);
    logic [CNT_W-1:0] count;

    assign terminal = (count == seg_len - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= terminal ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/chroma_sequencer.sv
// NTSC line sequencer: walks SYNC..FRONT per accepted sample and selects the
// mixer source (zero / burst reference / chroma) for each segment.
module chroma_sequencer
    import ntsc_pkg::*;
#(
    parameter int unsigned SYNC_SAMPLES   = DEF_SYNC_SAMPLES,
    parameter int unsigned BREEZE_SAMPLES = DEF_BREEZE_SAMPLES,
    parameter int unsigned BURST_SAMPLES  = DEF_BURST_SAMPLES,
    parameter int unsigned BACK_SAMPLES   = DEF_BACK_SAMPLES,
    parameter int unsigned ACTIVE_SAMPLES = DEF_ACTIVE_SAMPLES,
    parameter int unsigned FRONT_SAMPLES  = DEF_FRONT_SAMPLES,
    parameter int unsigned LINES          = DEF_LINES
) (
    input  logic              clk_in,
    input  logic              rst_in,
    chroma_sequencer_if.slave bus
);
    seq_state_t        state;
    chroma_sel_t       chroma_sel;
    logic              line_start;
    logic [LINE_W-1:0] line_count;
    logic [CNT_W-1:0]  seg_len;
    logic              run;
    logic              hold;
    logic              advance;
    logic              terminal;

    assign run     = bus.enable_in && (state != ST_IDLE);
    assign hold    = !run;
    assign advance = run && bus.step_in;

    always_comb begin
        seg_len = CNT_W'(SYNC_SAMPLES);
        case (state)
            ST_BREEZE: seg_len = CNT_W'(BREEZE_SAMPLES);
            ST_BURST:  seg_len = CNT_W'(BURST_SAMPLES);
            ST_BACK:   seg_len = CNT_W'(BACK_SAMPLES);
            ST_ACTIVE: seg_len = CNT_W'(ACTIVE_SAMPLES);
            ST_FRONT:  seg_len = CNT_W'(FRONT_SAMPLES);
            default:   seg_len = CNT_W'(SYNC_SAMPLES);
        endcase
    end

    line_timer u_line_timer (
        .clk      (clk_in),
        .rst      (rst_in),
        .clear    (hold),
        .advance  (advance),
        .seg_len  (seg_len),
        .terminal (terminal)
    );

    // Disable outranks a coincident terminal step, so the line count never bumps on exit.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= ST_IDLE;
            line_start <= 1'b0;
            line_count <= '0;
        end else if (!bus.enable_in) begin
            state      <= ST_IDLE;
            line_start <= 1'b0;
            line_count <= '0;
        end else if (state == ST_IDLE) begin
            state      <= ST_SYNC;
            line_start <= 1'b1;
        end else if (advance && terminal) begin
            state      <= next_state(state);
            line_start <= (state == ST_FRONT);
            if (state == ST_FRONT) begin
                line_count <= (line_count == LINE_W'(LINES - 1)) ? '0 : line_count + LINE_W'(1);
            end
        end else begin
            line_start <= 1'b0;
        end
    end

    always_comb begin
        chroma_sel = CSEL_ZERO;
        case (state)
            ST_BURST:  chroma_sel = CSEL_BURST;
            ST_ACTIVE: chroma_sel = CSEL_CHROMA;
            default:   chroma_sel = CSEL_ZERO;
        endcase
    end

    assign bus.chroma_sel_out = chroma_sel;
    assign bus.state_out      = state;
    assign bus.sync_out       = (state == ST_SYNC);
    assign bus.active_out     = (state == ST_ACTIVE);
    assign bus.lo_step_out    = advance;
    assign bus.line_start_out = line_start;
    assign bus.line_count_out = line_count;
endmodule

// File: tb/tb_chroma_sequencer.sv
// Bench for chroma_sequencer: three parameterisations checked every cycle
// against a step-count model of the line, plus literal timing expectations.
module tb_chroma_sequencer;
    import ntsc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic en_a = 1'b0, st_a = 1'b0;
    logic en_b = 1'b0, st_b = 1'b0;
    logic en_c = 1'b0, st_c = 1'b0;
    bit   done = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    chroma_sequencer_if ifc_a ();
    chroma_sequencer_if ifc_b ();
    chroma_sequencer_if ifc_c ();

    assign ifc_a.enable_in = en_a;
    assign ifc_a.step_in   = st_a;
    assign ifc_b.enable_in = en_b;
    assign ifc_b.step_in   = st_b;
    assign ifc_c.enable_in = en_c;
    assign ifc_c.step_in   = st_c;

    chroma_sequencer dut_a (.clk_in(clk), .rst_in(rst), .bus(ifc_a));

    chroma_sequencer #(
        .SYNC_SAMPLES(1), .BREEZE_SAMPLES(1), .BURST_SAMPLES(1),
        .BACK_SAMPLES(1), .ACTIVE_SAMPLES(1), .FRONT_SAMPLES(1), .LINES(3)
    ) dut_b (.clk_in(clk), .rst_in(rst), .bus(ifc_b));

    chroma_sequencer #(
        .SYNC_SAMPLES(3), .BREEZE_SAMPLES(1), .BURST_SAMPLES(2),
        .BACK_SAMPLES(1), .ACTIVE_SAMPLES(5), .FRONT_SAMPLES(2), .LINES(4)
    ) dut_c (.clk_in(clk), .rst_in(rst), .bus(ifc_c));

    // Model: a line is a run of accepted steps; position within it picks the segment.
    int unsigned seg [3][6] = '{'{940, 120, 500, 320, 10532, 300},
                                '{1, 1, 1, 1, 1, 1},
                                '{3, 1, 2, 1, 5, 2}};
    int unsigned nlines [3] = '{525, 3, 4};

    bit              m_run [3];
    longint unsigned m_s   [3];
    bit              m_ls  [3];

    function automatic longint unsigned llen(int k);
        longint unsigned t = 0;
        for (int i = 0; i < 6; i++) t += seg[k][i];
        return t;
    endfunction

    function automatic int exp_state(int k);
        longint unsigned off;
        longint unsigned acc = 0;
        if (!m_run[k]) return 0;
        off = m_s[k] % llen(k);
        for (int i = 0; i < 6; i++) begin
            acc += seg[k][i];
            if (off < acc) return i + 1;
        end
        return 7;
    endfunction

    function automatic int exp_line(int k);
        if (!m_run[k]) return 0;
        return int'((m_s[k] / llen(k)) % nlines[k]);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit ev [3];
        bit sv [3];
        ev[0] = en_a; ev[1] = en_b; ev[2] = en_c;
        sv[0] = st_a; sv[1] = st_b; sv[2] = st_c;
        for (int k = 0; k < 3; k++) begin
            if (rst || !ev[k]) begin
                m_run[k] = 1'b0; m_s[k] = 0; m_ls[k] = 1'b0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1; m_s[k] = 0; m_ls[k] = 1'b1;
            end else if (sv[k]) begin
                m_s[k]  = m_s[k] + 1;
                m_ls[k] = ((m_s[k] % llen(k)) == 0);
            end else begin
                m_ls[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut=%0d t=%0t actual=%0d required=%0d", name, k, $time, act, req);
        end
    endtask

    task automatic cmp(input int k, input logic [2:0] s, input logic sy, input logic ac,
                       input logic [1:0] cs, input logic ls, input logic lo,
                       input logic [9:0] ln, input logic inp);
        int es;
        es = exp_state(k);
        chk("state", k, s, es);
        chk("sync", k, sy, es == 1);
        chk("active", k, ac, es == 5);
        chk("chroma_sel", k, cs, (es == 3) ? 1 : (es == 5) ? 2 : 0);
        chk("line_start", k, ls, m_ls[k]);
        chk("lo_step", k, lo, m_run[k] && inp);
        chk("line_count", k, ln, exp_line(k));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp(0, ifc_a.state_out, ifc_a.sync_out, ifc_a.active_out, ifc_a.chroma_sel_out,
                ifc_a.line_start_out, ifc_a.lo_step_out, ifc_a.line_count_out, en_a & st_a);
            cmp(1, ifc_b.state_out, ifc_b.sync_out, ifc_b.active_out, ifc_b.chroma_sel_out,
                ifc_b.line_start_out, ifc_b.lo_step_out, ifc_b.line_count_out, en_b & st_b);
            cmp(2, ifc_c.state_out, ifc_c.sync_out, ifc_c.active_out, ifc_c.chroma_sel_out,
                ifc_c.line_start_out, ifc_c.lo_step_out, ifc_c.line_count_out, en_c & st_c);
        end
    end

    initial begin : rand_c
        while (!done) begin
            @(posedge clk);
            #2;
            en_c = ($urandom_range(99) < 97);
            st_c = ($urandom_range(99) < 60);
        end
    end

    task automatic chk_a_reset(input string tag);
        chk({tag, "_state"}, 0, ifc_a.state_out, 0);
        chk({tag, "_csel"}, 0, ifc_a.chroma_sel_out, 0);
        chk({tag, "_sync"}, 0, ifc_a.sync_out, 0);
        chk({tag, "_active"}, 0, ifc_a.active_out, 0);
        chk({tag, "_lstart"}, 0, ifc_a.line_start_out, 0);
        chk({tag, "_lo"}, 0, ifc_a.lo_step_out, 0);
        chk({tag, "_line"}, 0, ifc_a.line_count_out, 0);
    endtask

    initial begin : main
        int ls_q[$];
        int first_b = -1, last_b = -1, first_c = -1, last_c = -1;

        repeat (3) @(posedge clk);
        #2;
        chk_a_reset("rst");
        rst = 1'b0;

        // Continuous steps: line timing, then disable at ACTIVE count 5000 of line 1.
        @(posedge clk); #2;
        en_a = 1'b1; st_a = 1'b1;
        for (int c = 0; c <= 19592; c++) begin
            @(posedge clk); #2;
            if (ifc_a.line_start_out === 1'b1) ls_q.push_back(c);
            if (c < 12712) begin
                if (ifc_a.chroma_sel_out === 2'd1) begin
                    if (first_b < 0) first_b = c;
                    last_b = c;
                end
                if (ifc_a.chroma_sel_out === 2'd2) begin
                    if (first_c < 0) first_c = c;
                    last_c = c;
                end
            end
        end
        chk("ls_pulses", 0, ls_q.size(), 2);
        chk("ls_first", 0, (ls_q.size() > 0) ? ls_q[0] : -1, 0);
        chk("ls_second", 0, (ls_q.size() > 1) ? ls_q[1] : -1, 12712);
        chk("burst_first", 0, first_b, 1060);
        chk("burst_last", 0, last_b, 1559);
        chk("chroma_first", 0, first_c, 1880);
        chk("chroma_last", 0, last_c, 12411);
        chk("drop_pre_state", 0, ifc_a.state_out, 5);
        chk("drop_pre_line", 0, ifc_a.line_count_out, 1);
        en_a = 1'b0;
        @(posedge clk); #2;
        chk("drop_state", 0, ifc_a.state_out, 0);
        chk("drop_csel", 0, ifc_a.chroma_sel_out, 0);
        chk("drop_line", 0, ifc_a.line_count_out, 0);

        // Asynchronous reset in the middle of BURST.
        en_a = 1'b1;
        for (int c = 0; c <= 1200; c++) begin
            @(posedge clk); #2;
        end
        chk("burst_state", 0, ifc_a.state_out, 3);
        chk("burst_csel", 0, ifc_a.chroma_sel_out, 1);
        #1 rst = 1'b1;
        #1 chk_a_reset("async_rst");
        @(posedge clk); #2;
        rst = 1'b0;

        // Disable coinciding with the FRONT terminal step.
        for (int c = 0; c <= 12711; c++) begin
            @(posedge clk); #2;
        end
        chk("front_state", 0, ifc_a.state_out, 6);
        chk("front_line", 0, ifc_a.line_count_out, 0);
        en_a = 1'b0;
        @(posedge clk); #2;
        chk("front_drop_state", 0, ifc_a.state_out, 0);
        chk("front_drop_line", 0, ifc_a.line_count_out, 0);
        chk("front_drop_lstart", 0, ifc_a.line_start_out, 0);

        // Unit-length segments: one step per state, line count 0,1,2,0.
        en_b = 1'b1; st_b = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #2;
            chk("unit_state", 1, ifc_b.state_out, (c % 6) + 1);
            if (c % 6 == 0) begin
                chk("unit_line", 1, ifc_b.line_count_out, (c / 6) % 3);
                chk("unit_lstart", 1, ifc_b.line_start_out, 1);
            end
        end

        // Alternating step: states advance at half rate, LO strobe follows step.
        en_b = 1'b0;
        @(posedge clk); #2;
        en_b = 1'b1; st_b = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #2;
            chk("half_state", 1, ifc_b.state_out, ((c + 1) / 2) % 6 + 1);
            st_b = (c % 2 == 0);
            #1 chk("lo_mirror", 1, ifc_b.lo_step_out, (c % 2 == 0));
        end

        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
